pipe_reg_elastic: RTL
=====================

Name: pipe_reg_elastic

Overview:
- Parametrised, multi-stage register pipeline with a per-stage valid/ready (elastic) handshake. It generalises the single-bit D flip-flop to WIDTH-bit data across STAGES stages.
- Adds a programmable reset value, backpressure, flush and an occupancy count.
- Used wherever a datapath needs a fixed retiming delay that must also tolerate downstream stalls without dropping or duplicating data.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- STAGES, 3, number of register stages (>=1; elaboration error otherwise).
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).
- CNT_W, $clog2(STAGES+1), width of the occupancy output (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  pipeline accepts a beat this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  beat available at output.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  output data (the last stage register).
- flush  input  1  discard all in-flight beats.
- count  output  CNT_W  number of stages currently holding a valid beat.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset. All state changes on the rising edge of clk only.
- State: per stage i (0..STAGES-1), registers v[i] (1 bit) and d[i] (WIDTH bits). Stage 0 is the input stage; stage STAGES-1 drives out_data.
- Reset (reset=1 at the edge):
  - All v[i]=0 and all d[i]=RESET_VAL.
  - count=0.
  - Outputs after the edge: out_valid=0, out_data=RESET_VAL, in_ready=1.
  - reset has priority over flush and over all handshakes. A reset mid-stream discards all beats.
- Ready chain (combinational):
  - rdy[STAGES]=out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0] & !flush.
  - An empty stage, or a stage whose content moves on in the same cycle, can accept a beat. No bubble is required between beats.
- Stage advance, when not reset and not flush:
  - If rdy[i]: v[i] <= (i==0 ? in_valid : v[i-1]) and d[i] <= (i==0 ? in_data : d[i-1]).
  - Else stage i holds.
  - d[i] is loaded only when the incoming valid is 1. A bubble does not overwrite data (power), but v[i] still clears.
- Handshakes:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - out_valid = v[STAGES-1] & !flush.
  - out_data = d[STAGES-1], registered with no combinational path from in_data.
  - in_data/in_valid must be held by upstream while in_valid=1 and in_ready=0.
- Latency and throughput:
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles input-to-output, given no stalls.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, beats compact toward the output.
  - in_ready falls only when all STAGES stages are valid. Capacity is exactly STAGES beats.
  - Order is preserved, with no loss and no duplication.
- Flush (flush=1, reset=0):
  - In-cycle: in_ready=0 and out_valid=0, so no fire occurs in that cycle.
  - At the edge: all v[i]=0 and count=0. d[i] is unchanged.
  - Next cycle the pipeline is empty and in_ready=1.
- count:
  - Registered. It is updated to the popcount of the next-state v.
  - Equivalently, count +1 on input fire without output fire, -1 on output fire without input fire, unchanged otherwise. It is 0 on reset or flush.
  - Range is 0..STAGES.
- STAGES=1: a single elastic register. in_ready = !v[0] | out_ready.

Test Plan:
- Reset, WIDTH=8, STAGES=3, RESET_VAL=8'hA5: hold reset 2 cycles -> out_valid=0, out_data=8'hA5, in_ready=1, count=0.
- Streaming: out_ready=1; drive 0x01..0x0A on consecutive cycles -> 0x01 appears 3 cycles after acceptance, then one beat per cycle in order; count stays 3 in steady state.
- Backpressure: out_ready=0 and push 0x10,0x11,0x12,0x13 -> first 3 accepted, in_ready=0 on the 4th, count=3. Raise out_ready -> 0x10,0x11,0x12,0x13 delivered in order, none lost or repeated.
- Bubbles: in_valid pattern 1,0,1,0 with data 0x20,0x21 -> output shows 0x20, a gap, 0x21, with the same spacing shifted by 3 cycles.
- Flush: with 3 beats held (out_ready=0), pulse flush 1 cycle while in_valid=1 -> in_ready=0 and out_valid=0 that cycle; next cycle count=0 and out_valid=0; a subsequent beat 0x33 emerges 3 cycles after acceptance.
- Simultaneous reset+flush mid-stream, plus STAGES=1 variant: reset wins (out_data=RESET_VAL, count=0). With STAGES=1, out_ready=1 continuous -> 1-cycle latency at full rate; out_ready=0 -> in_ready=0 after one beat.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// -----------------------------------------------------------------------------
// pipe_reg_elastic
//
// Parametrised multi-stage register pipeline with a per-stage valid/ready
// (elastic) handshake. Each stage holds one beat (valid bit + WIDTH-bit data).
// A stage can accept a new beat when it is empty or when its own content moves
// on in the same cycle, so the pipeline streams at one beat per clock and
// compacts toward the output under backpressure without losing or duplicating
// beats. Capacity is exactly STAGES beats.
//
// Parameters:
//   WIDTH      data width in bits (>= 1)
//   STAGES     number of register stages (>= 1)
//   RESET_VAL  value loaded into every data register on reset
//   CNT_W      width of the occupancy count (derived)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (priority over flush/handshakes)
//   in_valid   upstream beat present
//   in_ready   pipeline accepts a beat this cycle
//   in_data    upstream data
//   out_valid  beat available at the output
//   out_ready  downstream accepts the beat
//   out_data   output data, straight from the last stage register
//   flush      discard all in-flight beats at the next edge
//   count      number of stages currently holding a valid beat
// -----------------------------------------------------------------------------
module pipe_reg_elastic #(
    parameter int                 WIDTH     = 8,
    parameter int                 STAGES    = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CNT_W     = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  flush,
    output logic [CNT_W-1:0]      count
);

    // A zero-stage pipeline has no meaning; stop elaboration rather than
    // silently building something odd.
    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_reg_elastic: STAGES must be >= 1");
    end

    // Number of set bits in a stage-valid vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [STAGES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < STAGES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Stage state: r_v[i] marks a valid beat in stage i, r_d[i] holds its data.
    logic [STAGES-1:0]  r_v;
    logic [WIDTH-1:0]   r_d [STAGES];
    logic [CNT_W-1:0]   r_cnt;

    // w_rdy[i]: stage i may take a beat this cycle. w_rdy[STAGES] is the
    // downstream ready.
    logic [STAGES:0]    w_rdy;

    // What each stage would load from its upstream neighbour.
    logic [STAGES-1:0]  w_v_in;
    logic [WIDTH-1:0]   w_d_in [STAGES];

    // Next-state valids and per-stage data load enables.
    logic [STAGES-1:0]  w_v_nxt;
    logic [STAGES-1:0]  w_ld;

    // Ready chain: a stage is ready when it is empty or everything in front of
    // it is able to move. This unrolls to "some stage is empty, or out_ready",
    // which is what lets beats compact toward the output during a stall.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_rdy[i] = ~r_v[i] | w_rdy[i+1];
        end
    end

    // Upstream neighbour of each stage: the input port for stage 0, the
    // previous stage register otherwise.
    always_comb begin
        w_v_in    = '0;
        w_v_in[0] = in_valid;
        w_d_in[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            w_v_in[i] = r_v[i-1];
            w_d_in[i] = r_d[i-1];
        end
    end

    // Next-state selection. In a flush cycle in_ready and out_valid are both
    // forced low, so no beat enters or leaves and every stage simply empties.
    // Data is loaded only alongside a valid beat: a bubble clears the valid
    // bit but leaves the data register untouched to avoid needless toggling.
    always_comb begin
        w_v_nxt = r_v;
        w_ld    = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush) begin
                w_v_nxt[i] = 1'b0;
            end else if (w_rdy[i]) begin
                w_v_nxt[i] = w_v_in[i];
                w_ld[i]    = w_v_in[i];
            end
        end
    end

    // Stage registers and occupancy count. Reset wins over flush and over any
    // handshake; the count tracks the popcount of the next-state valids so it
    // is always consistent with the stage contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_d[i] <= RESET_VAL;
            end
        end else begin
            r_v   <= w_v_nxt;
            r_cnt <= popcount(w_v_nxt);
            for (int i = 0; i < STAGES; i++) begin
                if (w_ld[i]) begin
                    r_d[i] <= w_d_in[i];
                end
            end
        end
    end

    // Output side: out_data comes straight from the last register, so there
    // is no combinational path from in_data to out_data.
    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = r_v[STAGES-1] & ~flush;
    assign out_data  = r_d[STAGES-1];
    assign count     = r_cnt;

endmodule
